vga_pattern_top: RTL and testbench

- Top-level VGA video source for a 640x480@60 Hz display driven from the 50 MHz board clock.
- Divides clock_50 by 2 to produce the 25 MHz pixel clock (vgaclock).
- Generates hsync, vsync and n_blank timing for a DAC with an active-low blank input, such as the ADV7123.
- Drives 8-bit R/G/B pixel data from a built-in test-pattern generator selected by one input.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_if.sv | 28 ++
 rtl/vga_timing.sv | 54 +++++
 rtl/vga_pattern_top.sv | 81 ++++++++
 tb/tb_vga_pattern_top.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the 640x480@60 VGA pattern source.
// Holds the timing constants, counter widths, the RGB payload struct,
// the pattern-select enum and the colour-bar lookup helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned H_FP         = 16;
  localparam int unsigned H_SYNC       = 96;
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned V_SYNC_START = 491;
  localparam int unsigned V_SYNC       = 2;
  localparam int unsigned V_TOTAL      = 525;

  localparam int unsigned H_W   = 10;
  localparam int unsigned V_W   = 10;
  localparam int unsigned CH_W  = 8;
  localparam int unsigned BAR_W = 80;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    PAT_BARS    = 1'b0,
    PAT_CHECKER = 1'b1
  } pat_sel_t;

  // Bar index bits map straight onto the R/G/B channels (bit2=R, bit1=G, bit0=B).
  function automatic rgb_t bar_color(input logic [2:0] bar);
    rgb_t c;
    c.r = {CH_W{bar[2]}};
    c.g = {CH_W{bar[1]}};
    c.b = {CH_W{bar[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Video output bundle of the pattern source.
// sel       : pattern select into the source (0 = bars, 1 = checkerboard)
// red/green/blue_out : 8-bit channels, declared [0:7] so bit 0 is the MSB
// hsync/vsync : active-low syncs; n_blank : 1 on visible pixels
// vgaclock  : 25 MHz pixel clock
interface vga_if;
  import vga_pkg::*;

  logic            sel;
  logic [0:CH_W-1] red_out;
  logic [0:CH_W-1] green_out;
  logic [0:CH_W-1] blue_out;
  logic            hsync;
  logic            vsync;
  logic            n_blank;
  logic            vgaclock;

  modport master (
    input  sel,
    output red_out, green_out, blue_out, hsync, vsync, n_blank, vgaclock
  );

  modport slave (
    output sel,
    input  red_out, green_out, blue_out, hsync, vsync, n_blank, vgaclock
  );

endinterface

// File: rtl/vga_timing.sv
// Raster timing: pixel-enable divider, h/v counters and sync/blank decode.
// Ports: clk, rst (sync, active-high); pix_en (registered divide-by-2 enable);
// hcount (registered column); v_tile_c (vcount bit 5 for the checkerboard);
// hsync_c/vsync_c/n_blank_c (combinational decode of the current counters).
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned V_ACT = V_ACTIVE,
  parameter int unsigned V_SS  = V_SYNC_START,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_TOT = V_TOTAL
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pix_en,
  output logic [H_W-1:0] hcount,
  output logic           v_tile_c,
  output logic           hsync_c,
  output logic           vsync_c,
  output logic           n_blank_c
);

  logic [V_W-1:0] vcount;

  // Counters advance on the second clock of each pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcount == H_W'(H_TOTAL - 1)) begin
          hcount <= '0;
          if (vcount == V_W'(V_TOT - 1)) vcount <= '0;
          else                           vcount <= vcount + V_W'(1);
        end else begin
          hcount <= hcount + H_W'(1);
        end
      end
    end
  end

  // Sync/blank decode; registered together with RGB in the top level.
  always_comb begin
    hsync_c   = !((hcount >= H_W'(H_ACTIVE + H_FP)) &&
                  (hcount <= H_W'(H_ACTIVE + H_FP + H_SYNC - 1)));
    vsync_c   = !((vcount >= V_W'(V_SS)) && (vcount <= V_W'(V_SS + V_SW - 1)));
    n_blank_c = (hcount < H_W'(H_ACTIVE)) && (vcount < V_W'(V_ACT));
    v_tile_c  = vcount[5];
  end

endmodule

// File: rtl/vga_pattern_top.sv
// VGA 640x480@60 test-pattern source running from the 50 MHz board clock.
// Ports: clock_50 (50 MHz), reset (sync, active-high), vga (master side of
// vga_if: sel in; RGB, hsync, vsync, n_blank, vgaclock out).
// Each pixel's outputs are captured on the edge where vgaclock rises.
module vga_pattern_top
  import vga_pkg::*;
#(
  parameter int unsigned V_ACT = V_ACTIVE,
  parameter int unsigned V_SS  = V_SYNC_START,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_TOT = V_TOTAL
) (
  input  logic clock_50,
  input  logic reset,
  vga_if.master vga
);

  logic           pix_en;
  logic [H_W-1:0] hcount;
  logic           v_tile_c;
  logic           hsync_c;
  logic           vsync_c;
  logic           n_blank_c;
  rgb_t           pix_c;
  rgb_t           rgb_q;
  logic           hsync_q;
  logic           vsync_q;
  logic           n_blank_q;

  vga_timing #(
    .V_ACT (V_ACT),
    .V_SS  (V_SS),
    .V_SW  (V_SW),
    .V_TOT (V_TOT)
  ) u_timing (
    .clk       (clock_50),
    .rst       (reset),
    .pix_en    (pix_en),
    .hcount    (hcount),
    .v_tile_c  (v_tile_c),
    .hsync_c   (hsync_c),
    .vsync_c   (vsync_c),
    .n_blank_c (n_blank_c)
  );

  // Pattern generator; black outside the active area.
  always_comb begin
    pix_c = '0;
    if (n_blank_c) begin
      if (pat_sel_t'(vga.sel) == PAT_CHECKER) begin
        if (hcount[5] ^ v_tile_c) pix_c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
      end else begin
        pix_c = bar_color(3'(hcount / H_W'(BAR_W)));
      end
    end
  end

  // Output registers load while pix_en is low, i.e. on the vgaclock rising edge.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      rgb_q     <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      n_blank_q <= 1'b0;
    end else if (!pix_en) begin
      rgb_q     <= pix_c;
      hsync_q   <= hsync_c;
      vsync_q   <= vsync_c;
      n_blank_q <= n_blank_c;
    end
  end

  assign vga.red_out   = rgb_q.r;
  assign vga.green_out = rgb_q.g;
  assign vga.blue_out  = rgb_q.b;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.n_blank   = n_blank_q;
  assign vga.vgaclock  = pix_en;

endmodule

// File: tb/tb_vga_pattern_top.sv
// Bench for vga_pattern_top: a full-size instance plus a short-frame instance,
// both checked every cycle against a pixel-index reference model.
module tb_vga_pattern_top;
  import vga_pkg::*;

  localparam int unsigned SV_ACT = 6;
  localparam int unsigned SV_SS  = 8;
  localparam int unsigned SV_SW  = 2;
  localparam int unsigned SV_TOT = 11;

  typedef struct {
    int          h;
    int          v;
    bit          s;
    logic [23:0] rgb;
    bit          hs;
    bit          vs;
    bit          nb;
  } probe_t;

  logic clk = 1'b0;
  logic reset;
  logic sel;

  always #10 clk = ~clk;

  vga_if bus ();
  vga_if bus_s ();
  assign bus.sel   = sel;
  assign bus_s.sel = sel;

  vga_pattern_top dut (
    .clock_50 (clk),
    .reset    (reset),
    .vga      (bus)
  );

  vga_pattern_top #(
    .V_ACT (SV_ACT),
    .V_SS  (SV_SS),
    .V_SW  (SV_SW),
    .V_TOT (SV_TOT)
  ) dut_s (
    .clock_50 (clk),
    .reset    (reset),
    .vga      (bus_s)
  );

  int     total = 0;
  int     bad   = 0;
  int     n     = 0;     // clock edges since reset released (0 = in reset)
  bit     pix_sel = 1'b0;
  int     cyc   = 0;
  int     hs_low = 0;
  int     nb_low = 0;
  int     falls = 0;
  int     last_fall = 0;
  int     vs_low_cnt = 0;
  logic   prev_vs_s = 1'b1;
  probe_t tbl[$];
  int     hits[$];

  // Expected {vgaclock, hsync, vsync, n_blank, R, G, B} after edge k of a scan.
  function automatic logic [27:0] expect_out(input int k, input bit s, input int v_act,
                                             input int v_ss, input int v_sw, input int v_tot);
    int p, h, v, bar;
    bit vis, hs, vs;
    logic [23:0] rgb;
    if (k == 0) return {1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    p   = (k - 1) / 2;
    h   = p % 800;
    v   = (p / 800) % v_tot;
    vis = (h < 640) && (v < v_act);
    hs  = !(h >= 656 && h < 752);
    vs  = !(v >= v_ss && v < v_ss + v_sw);
    rgb = 24'h0;
    if (vis) begin
      if (s) begin
        if (((h / 32) + (v / 32)) % 2 == 1) rgb = 24'hFFFFFF;
      end else begin
        bar = h / 80;
        rgb = {((bar & 4) != 0) ? 8'hFF : 8'h00,
               ((bar & 2) != 0) ? 8'hFF : 8'h00,
               ((bar & 1) != 0) ? 8'hFF : 8'h00};
      end
    end
    return {1'(k % 2), hs, vs, vis, rgb};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d n=%0d actual=%h required=%h", name, cyc, n, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add_probe(input int h, input int v, input bit s, input logic [23:0] rgb,
                           input bit hs, input bit vs, input bit nb);
    probe_t e;
    e.h = h; e.v = v; e.s = s; e.rgb = rgb; e.hs = hs; e.vs = vs; e.nb = nb;
    tbl.push_back(e);
    hits.push_back(0);
  endtask

  function automatic logic [27:0] main_out();
    return {bus.vgaclock, bus.hsync, bus.vsync, bus.n_blank,
            bus.red_out, bus.green_out, bus.blue_out};
  endfunction

  task automatic step();
    bit s_now, r_now;
    int p, h, v;
    logic [27:0] act;
    s_now = sel;
    r_now = reset;
    @(posedge clk);
    #1;
    cyc++;
    if (r_now) n = 0;
    else begin
      n++;
      if (n % 2 == 1) pix_sel = s_now;
    end
    act = main_out();
    check("main", act, expect_out(n, pix_sel, V_ACTIVE, V_SYNC_START, V_SYNC, V_TOTAL));
    check("small", {bus_s.vgaclock, bus_s.hsync, bus_s.vsync, bus_s.n_blank,
                    bus_s.red_out, bus_s.green_out, bus_s.blue_out},
          expect_out(n, pix_sel, SV_ACT, SV_SS, SV_SW, SV_TOT));
    if (n % 2 == 1) begin
      p = (n - 1) / 2;
      h = p % 800;
      v = (p / 800) % 525;
      if (v == 10) begin
        if (!bus.hsync)   hs_low++;
        if (!bus.n_blank) nb_low++;
      end
      foreach (tbl[i]) begin
        if (tbl[i].h == h && tbl[i].v == v && tbl[i].s == pix_sel) begin
          hits[i]++;
          check($sformatf("probe_%0d_%0d", h, v), {1'b0, act[26:0]},
                {1'b0, tbl[i].hs, tbl[i].vs, tbl[i].nb, tbl[i].rgb});
        end
      end
    end
    // Short-frame instance: vsync period and pulse width from its outputs.
    if (prev_vs_s === 1'b1 && bus_s.vsync === 1'b0) begin
      falls++;
      if (falls > 1) begin
        check_int("frame_period", cyc - last_fall, int'(SV_TOT) * 1600);
        check_int("vsync_width", vs_low_cnt, int'(SV_SW) * 1600);
      end
      last_fall  = cyc;
      vs_low_cnt = 0;
    end
    if (bus_s.vsync === 1'b0) vs_low_cnt++;
    prev_vs_s = bus_s.vsync;
  endtask

  // Forced select in probe windows, random elsewhere.
  task automatic drive_and_step();
    int p, h, v;
    sel = 1'($urandom % 2);
    if (!reset && (n % 2 == 0)) begin
      p = n / 2;
      h = p % 800;
      v = (p / 800) % 525;
      if ((v == 0 || v == 32) && h < 64) sel = 1'b1;
      else if (v == 10)                   sel = 1'b0;
    end
    step();
  endtask

  initial begin
    bit reached;
    add_probe(0,   0,  1'b1, 24'h000000, 1, 1, 1);
    add_probe(32,  0,  1'b1, 24'hFFFFFF, 1, 1, 1);
    add_probe(32,  32, 1'b1, 24'h000000, 1, 1, 1);
    add_probe(0,   32, 1'b1, 24'hFFFFFF, 1, 1, 1);
    add_probe(0,   10, 1'b0, 24'h000000, 1, 1, 1);
    add_probe(79,  10, 1'b0, 24'h000000, 1, 1, 1);
    add_probe(80,  10, 1'b0, 24'h0000FF, 1, 1, 1);
    add_probe(240, 10, 1'b0, 24'h00FFFF, 1, 1, 1);
    add_probe(320, 10, 1'b0, 24'hFF0000, 1, 1, 1);
    add_probe(400, 10, 1'b0, 24'hFF00FF, 1, 1, 1);
    add_probe(480, 10, 1'b0, 24'hFFFF00, 1, 1, 1);
    add_probe(560, 10, 1'b0, 24'hFFFFFF, 1, 1, 1);
    add_probe(639, 10, 1'b0, 24'hFFFFFF, 1, 1, 1);
    add_probe(640, 10, 1'b0, 24'h000000, 1, 1, 0);
    add_probe(655, 10, 1'b0, 24'h000000, 1, 1, 0);
    add_probe(656, 10, 1'b0, 24'h000000, 0, 1, 0);
    add_probe(751, 10, 1'b0, 24'h000000, 0, 1, 0);
    add_probe(752, 10, 1'b0, 24'h000000, 1, 1, 0);
    add_probe(799, 10, 1'b0, 24'h000000, 1, 1, 0);

    reset = 1'b1;
    sel   = 1'b0;
    repeat (4) step();
    check("reset_state", main_out(), 28'h6000000);
    reset = 1'b0;

    // Run to line 33, pixel 300 (bounded).
    reached = 1'b0;
    for (int i = 0; i < 60000; i++) begin
      if (n % 2 == 1 && (n - 1) / 2 == 33 * 800 + 300) begin
        reached = 1'b1;
        break;
      end
      drive_and_step();
    end
    check_int("reach_mid_frame", int'(reached), 1);

    // Mid-frame reset and restart from pixel (0,0).
    reset = 1'b1;
    step();
    check("mid_reset", main_out(), 28'h6000000);
    step();
    reset = 1'b0;
    sel   = 1'b0;
    step();
    check("restart_px0", main_out(), 28'hF000000);
    step();
    check("restart_px0_low", main_out(), 28'h7000000);
    repeat (1700) drive_and_step();

    check_int("hsync_low_pixels", hs_low, 96);
    check_int("blank_pixels", nb_low, 160);
    check_int("frames_seen", int'(falls >= 3), 1);
    foreach (hits[i]) check_int($sformatf("probe_hit_%0d", i), int'(hits[i] > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
